// File: rtl/riscv_cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_cpu_pkg : shared types and helpers for the load/store unit     |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package riscv_cpu_pkg;

  typedef enum logic [1:0] {
    BYTE   = 2'b00,
    HALF   = 2'b01,
    WORD   = 2'b10,
    DOUBLE = 2'b11
  } lsu_data_type_e;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_GNT    = 2'b01,
    WAIT_RVALID = 2'b10
  } lsu_state_e;

  // A double access is always misaligned on a bus without a 64-bit lane.
  function automatic logic lsu_misaligned(input lsu_data_type_e dtype,
                                          input logic [2:0]     addr_lsb,
                                          input logic           has_double);
    logic mis;
    case (dtype)
      BYTE:    mis = 1'b0;
      HALF:    mis = addr_lsb[0];
      WORD:    mis = |addr_lsb[1:0];
      default: mis = !has_double || (|addr_lsb);
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_bus_if : request/grant/rvalid data-memory bus of the LSU         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
interface lsu_bus_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    data_req_o;
  logic                    data_gnt_i;
  logic                    data_rvalid_i;
  logic [ADDR_WIDTH-1:0]   data_addr_o;
  logic                    data_we_o;
  logic [DATA_WIDTH/8-1:0] data_be_o;
  logic [DATA_WIDTH-1:0]   data_wdata_o;
  logic [DATA_WIDTH-1:0]   data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/lsu_data_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_data_align : byte enables, store lane shift, load extract/extend |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module lsu_data_align
  import riscv_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  lsu_data_type_e                      wr_type_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]     wr_offset_i,
  input  logic [DATA_WIDTH-1:0]               wdata_i,
  output logic [DATA_WIDTH/8-1:0]             be_o,
  output logic [DATA_WIDTH-1:0]               wdata_o,
  input  lsu_data_type_e                      rd_type_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]     rd_offset_i,
  input  logic                                rd_sign_ext_i,
  input  logic [DATA_WIDTH-1:0]               rdata_i,
  output logic [DATA_WIDTH-1:0]               rdata_o
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [7:0]            be_base;
  logic [15:0]           be_wide;
  logic [DATA_WIDTH-1:0] rd_shifted;
  logic [DATA_WIDTH-1:0] rd_mask;
  logic                  rd_sign;

  always_comb begin
    be_base = 8'h00;
    case (wr_type_i)
      BYTE:    be_base = 8'h01;
      HALF:    be_base = 8'h03;
      WORD:    be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    be_wide = {8'h00, be_base} << wr_offset_i;
  end

  assign be_o    = be_wide[BE_W-1:0];
  assign wdata_o = wdata_i << {wr_offset_i, 3'b000};

  assign rd_shifted = rdata_i >> {rd_offset_i, 3'b000};

  // Extension fills every bit above the access size, so a full-width
  // access has an empty fill mask and passes through untouched.
  always_comb begin
    rd_mask = '1;
    rd_sign = rd_shifted[DATA_WIDTH-1];
    case (rd_type_i)
      BYTE: begin
        rd_mask = DATA_WIDTH'(8'hFF);
        rd_sign = rd_shifted[7];
      end
      HALF: begin
        rd_mask = DATA_WIDTH'(16'hFFFF);
        rd_sign = rd_shifted[15];
      end
      WORD: begin
        rd_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        rd_sign = rd_shifted[31];
      end
      default: begin
        rd_mask = '1;
        rd_sign = rd_shifted[DATA_WIDTH-1];
      end
    endcase
    rdata_o = (rd_shifted & rd_mask) | ((rd_sign_ext_i && rd_sign) ? ~rd_mask : '0);
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit : single-outstanding LSU between pipeline and bus    |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module load_store_unit
  import riscv_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_data_type_i,
  input  logic                  mem_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_valid_o,
  output logic                  busy_o,
  output logic                  misaligned_o,
  lsu_bus_if.master             bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);

  lsu_state_e            state_q,  state_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic                  we_q,     we_d;
  logic [BE_W-1:0]       be_q,     be_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  lsu_data_type_e        type_q,   type_d;
  logic [OFF_W-1:0]      offset_q, offset_d;
  logic                  sign_q,   sign_d;
  logic                  valid_q,  valid_d;
  logic                  mis_q,    mis_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

  lsu_data_type_e        req_type;
  logic [OFF_W-1:0]      req_offset;
  logic [ADDR_WIDTH-1:0] req_addr_aligned;
  logic                  req_misaligned;
  logic                  issue;
  logic [BE_W-1:0]       req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] load_data;

  assign req_type         = lsu_data_type_e'(mem_data_type_i);
  assign req_offset       = mem_addr_i[OFF_W-1:0];
  assign req_addr_aligned = {mem_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign req_misaligned   = lsu_misaligned(req_type, mem_addr_i[2:0], DATA_WIDTH == 64);

  // Gated by rst_ni so the combinational request path is quiet during reset.
  assign issue = rst_ni && (state_q == IDLE) && mem_req_i && !req_misaligned;

  lsu_data_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .wr_type_i     (req_type),
    .wr_offset_i   (req_offset),
    .wdata_i       (mem_wdata_i),
    .be_o          (req_be),
    .wdata_o       (req_wdata),
    .rd_type_i     (type_q),
    .rd_offset_i   (offset_q),
    .rd_sign_ext_i (sign_q),
    .rdata_i       (bus.data_rdata_i),
    .rdata_o       (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      type_q   <= BYTE;
      offset_q <= '0;
      sign_q   <= 1'b0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      type_q   <= type_d;
      offset_q <= offset_d;
      sign_q   <= sign_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    type_d   = type_q;
    offset_d = offset_q;
    sign_d   = sign_q;
    valid_d  = 1'b0;
    mis_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          if (req_misaligned) begin
            mis_d = 1'b1;
          end else begin
            addr_d   = req_addr_aligned;
            we_d     = mem_we_i;
            be_d     = req_be;
            wdata_d  = req_wdata;
            type_d   = req_type;
            offset_d = req_offset;
            sign_d   = mem_sign_ext_i;
            state_d  = bus.data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        if (bus.data_gnt_i) begin
          state_d = WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (bus.data_rvalid_i) begin
          state_d = IDLE;
          valid_d = 1'b1;
          if (!we_q) begin
            rdata_d = load_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields come straight from the pipeline in the issue cycle and
  // from the captured copy while the grant is outstanding.
  assign bus.data_req_o   = issue || (state_q == WAIT_GNT);
  assign bus.data_addr_o  = issue ? req_addr_aligned : addr_q;
  assign bus.data_we_o    = issue ? mem_we_i         : we_q;
  assign bus.data_be_o    = issue ? req_be           : be_q;
  assign bus.data_wdata_o = issue ? req_wdata        : wdata_q;

  assign busy_o       = issue || (state_q != IDLE);
  assign mem_valid_o  = valid_q;
  assign misaligned_o = mis_q;
  assign mem_rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 SHALL have port clk_i  in  1  system clock, rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port mem_req_i  in  1  pipeline requests a load/store this cycle.
REQ-006 SHALL have port mem_we_i  in  1  1 = store, 0 = load.
REQ-007 SHALL have port mem_data_type_i  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-008 SHALL have port mem_sign_ext_i  in  1  sign-extend load result.
REQ-009 SHALL have port mem_addr_i  in  ADDR_WIDTH  byte address.
REQ-010 SHALL have port mem_wdata_i  in  DATA_WIDTH  store data, LSB-justified.
REQ-011 SHALL have port mem_rdata_o  out  DATA_WIDTH  aligned, extended load data.
REQ-012 SHALL have port mem_valid_o  out  1  one-cycle completion pulse for loads and stores.
REQ-013 SHALL have port busy_o  out  1  stall request to the pipeline.
REQ-014 SHALL have port misaligned_o  out  1  one-cycle misaligned-access pulse.
REQ-015 SHALL have bus ports data_req_o out 1, data_gnt_i in 1, data_rvalid_i in 1, data_addr_o out ADDR_WIDTH, data_we_o out 1, data_be_o out DATA_WIDTH/8, data_wdata_o out DATA_WIDTH, data_rdata_i in DATA_WIDTH.

Function
REQ-016 SHALL implement FSM IDLE, WAIT_GNT, WAIT_RVALID with exactly one outstanding bus transaction.
REQ-017 SHALL, in IDLE with mem_req_i=1 and an aligned access, assert data_req_o combinationally in the same cycle: data_addr_o = mem_addr_i with offset bits cleared; data_be_o from size and offset; data_wdata_o = mem_wdata_i shifted to the offset lane.
REQ-018 SHALL move IDLE to WAIT_RVALID if data_gnt_i=1 in that cycle, otherwise to WAIT_GNT, registering the request.
REQ-019 SHALL, in WAIT_GNT, hold data_req_o=1 and all request fields stable from registers until data_gnt_i=1, then move to WAIT_RVALID.
REQ-020 SHALL, in WAIT_RVALID, drive data_req_o=0 and, on data_rvalid_i=1, return to IDLE, pulse mem_valid_o in the next cycle, and for loads register mem_rdata_o.
REQ-021 SHALL form load data by shifting data_rdata_i right by 8*offset, masking to size, then sign- or zero-extending per mem_sign_ext_i.
REQ-022 SHALL hold mem_rdata_o until the next load completes; stores do not change it.
REQ-023 SHALL drive busy_o=1 in WAIT_GNT, in WAIT_RVALID, and in IDLE when mem_req_i=1 with an aligned access; otherwise 0.
REQ-024 SHALL treat as misaligned: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0. Size 11 with DATA_WIDTH=32 counts as misaligned.
REQ-025 SHALL, on a misaligned request in IDLE, issue no bus request, pulse misaligned_o in the next cycle, leave mem_valid_o=0, and stay in IDLE.
REQ-026 SHALL ignore mem_req_i outside IDLE; the pipeline holds its request while busy_o=1.
REQ-027 SHALL ignore data_rvalid_i in IDLE and WAIT_GNT, and data_gnt_i outside the cycles where data_req_o=1.

Reset
REQ-028 SHALL, while rst_ni=0, force state IDLE and all outputs 0, including mem_rdata_o, mem_valid_o, misaligned_o and busy_o.
REQ-029 SHALL abandon any in-flight transaction on reset; a late rvalid after reset is ignored per REQ-027.

Structure
REQ-030 SHALL place lsu_data_type_e (BYTE, HALF, WORD, DOUBLE) and lsu_state_e in riscv_cpu_pkg.
REQ-031 SHALL put byte-enable generation, write-lane shifting and read extraction/extension in a combinational sub-module lsu_data_align.

Verification
REQ-032 Word store to 0x100, data 0xDEADBEEF, gnt in the same cycle, rvalid 1 cycle later -> data_be_o=1111, data_addr_o=0x100; mem_valid_o pulses 1 cycle after rvalid; busy_o high 2 cycles.
REQ-033 Signed byte load at 0x103, bus rdata 0x80AABBCC -> mem_rdata_o=0xFFFFFF80, data_be_o=1000, data_addr_o=0x100.
REQ-034 Unsigned half load at 0x102, gnt delayed 3 cycles -> request fields stable through WAIT_GNT; rdata 0x1234ABCD gives mem_rdata_o=0x00001234.
REQ-035 Word load at 0x101 -> no data_req_o, misaligned_o pulses once, mem_valid_o stays 0.
REQ-036 rst_ni low in WAIT_RVALID, then rvalid after release -> outputs 0 and no mem_valid_o.
REQ-037 DATA_WIDTH=64: signed double load at 0x8 -> data_be_o=0xFF, full 64-bit data returned; signed word load at 0xC -> upper lane extracted and sign-extended.
